an_sec_decoder: RTL and testbench

AN_SEC_DECODER -- requirements
Module: an_sec_decoder

---
 rtl/an_sec_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_an_sec_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/an_sec_decoder.sv
// ---------------------------------------------------------------------------
// an_sec_decoder
//
// Purpose:
//   Decodes an AN-coded word (W = A*N, A odd) and corrects a single arithmetic
//   error of the form +/-2^k. A serial restoring divider produces the
//   quotient and residue. A nonzero residue starts a search over the powers of
//   two mod A. A match corrects W and runs a second division pass. If no
//   position matches, the floor quotient of the original word is reported.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   W is valid this cycle
//   in_ready   block can accept W (only while idle)
//   W          received codeword, W_BITS wide
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   N          decoded (corrected) data, N_BITS wide
//   err_det    nonzero residue was detected
//   err_corr   a single error was located and corrected
//   err_pos    corrected bit position k
//   err_neg    1 = error was -2^k (fixed by adding), 0 = +2^k
//   uncorr     (AN_SEC_UNCORR_EN only) error detected but no position matched
//
// Configuration macro:
//   AN_SEC_UNCORR_EN  adds the uncorr output port
// ---------------------------------------------------------------------------
module an_sec_decoder #(
  parameter int A      = 67,
  parameter int W_BITS = 32,
  parameter int N_BITS = 25,
  parameter int A_BITS = 7,
  parameter int L_MAX  = 33,
  parameter int K_BITS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_BITS-1:0] W,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] N,
  output logic              err_det,
  output logic              err_corr,
  output logic [K_BITS-1:0] err_pos,
  output logic              err_neg
`ifdef AN_SEC_UNCORR_EN
  ,
  output logic              uncorr
`endif
);

  // One extra dividend bit so that W + 2^k cannot overflow during correction.
  localparam int DW = W_BITS + 1;
  localparam int CW = $clog2(DW + 1);
  localparam logic [A_BITS:0]   A_EXT = (A_BITS + 1)'(A);
  localparam logic [A_BITS-1:0] A_RES = A_BITS'(A);

  typedef enum logic [2:0] {IDLE, DIV, SRCH, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     w_q, w_d;
  logic [DW-1:0]     sh_q, sh_d;
  logic [A_BITS-1:0] r_q, r_d;
  logic [A_BITS-1:0] p_q, p_d;
  logic [K_BITS-1:0] k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pass2_q, pass2_d;
  logic [N_BITS-1:0] n_q, n_d;
  logic              det_q, det_d;
  logic              corr_q, corr_d;
  logic              neg_q, neg_d;
  logic [K_BITS-1:0] pos_q, pos_d;
`ifdef AN_SEC_UNCORR_EN
  logic              uncorr_q, uncorr_d;
`endif

  // Restoring division step. sh_q shifts the dividend out at the MSB and
  // shifts quotient bits in at the LSB. After DW steps it holds the quotient.
  logic [A_BITS:0]   rem_shift;
  logic              rem_ge;
  logic [A_BITS-1:0] rem_sub;
  logic [A_BITS-1:0] rem_next;
  logic [DW-1:0]     sh_next;

  assign rem_shift = {r_q, sh_q[DW-1]};
  assign rem_ge    = (rem_shift >= A_EXT);
  assign rem_sub   = A_BITS'(rem_shift - A_EXT);
  assign rem_next  = rem_ge ? rem_sub : rem_shift[A_BITS-1:0];
  assign sh_next   = {sh_q[DW-2:0], rem_ge};

  // Search helpers. p_q tracks 2^k mod A, so one doubling per position.
  logic [A_BITS:0]   p_dbl;
  logic [A_BITS-1:0] p_sub;
  logic [A_BITS-1:0] p_next;
  logic              match_pos;
  logic              match_neg;
  logic [DW-1:0]     two_k;
  logic [DW-1:0]     w_fixed;

  assign p_dbl     = {p_q, 1'b0};
  assign p_sub     = A_BITS'(p_dbl - A_EXT);
  assign p_next    = (p_dbl >= A_EXT) ? p_sub : p_dbl[A_BITS-1:0];
  assign match_pos = (p_q == r_q);
  assign match_neg = ((A_RES - p_q) == r_q);
  assign two_k     = DW'(1) << k_q;
  assign w_fixed   = neg_q ? (w_q + two_k) : (w_q - two_k);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      w_q      <= '0;
      sh_q     <= '0;
      r_q      <= '0;
      p_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      pass2_q  <= 1'b0;
      n_q      <= '0;
      det_q    <= 1'b0;
      corr_q   <= 1'b0;
      neg_q    <= 1'b0;
      pos_q    <= '0;
`ifdef AN_SEC_UNCORR_EN
      uncorr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      sh_q     <= sh_d;
      r_q      <= r_d;
      p_q      <= p_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      pass2_q  <= pass2_d;
      n_q      <= n_d;
      det_q    <= det_d;
      corr_q   <= corr_d;
      neg_q    <= neg_d;
      pos_q    <= pos_d;
`ifdef AN_SEC_UNCORR_EN
      uncorr_q <= uncorr_d;
`endif
    end
  end

  // Next-state logic. Every register holds its value unless a state updates it.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    sh_d     = sh_q;
    r_d      = r_q;
    p_d      = p_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    pass2_d  = pass2_q;
    n_d      = n_q;
    det_d    = det_q;
    corr_d   = corr_q;
    neg_d    = neg_q;
    pos_d    = pos_q;
`ifdef AN_SEC_UNCORR_EN
    uncorr_d = uncorr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d      = DW'(W);
          sh_d     = DW'(W);
          r_d      = '0;
          cnt_d    = '0;
          pass2_d  = 1'b0;
          k_d      = '0;
          p_d      = A_BITS'(1);
          det_d    = 1'b0;
          corr_d   = 1'b0;
          neg_d    = 1'b0;
          pos_d    = '0;
`ifdef AN_SEC_UNCORR_EN
          uncorr_d = 1'b0;
`endif
          state_d  = DIV;
        end
      end
      DIV: begin
        sh_d  = sh_next;
        r_d   = rem_next;
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(DW - 1)) begin
          // The first-pass quotient is kept as the fallback result when the
          // search later finds no position.
          n_d = sh_next[N_BITS-1:0];
          if (pass2_q || (rem_next == '0)) begin
            state_d = DONE;
          end else begin
            det_d   = 1'b1;
            state_d = SRCH;
          end
        end
      end
      SRCH: begin
        if (match_pos) begin
          neg_d   = 1'b0;
          pos_d   = k_q;
          corr_d  = 1'b1;
          state_d = FIX;
        end else if (match_neg) begin
          neg_d   = 1'b1;
          pos_d   = k_q;
          corr_d  = 1'b1;
          state_d = FIX;
        end else if (k_q == K_BITS'(L_MAX - 1)) begin
`ifdef AN_SEC_UNCORR_EN
          uncorr_d = 1'b1;
`endif
          state_d = DONE;
        end else begin
          p_d = p_next;
          k_d = K_BITS'(k_q + 1'b1);
        end
      end
      FIX: begin
        w_d     = w_fixed;
        sh_d    = w_fixed;
        r_d     = '0;
        cnt_d   = '0;
        pass2_d = 1'b1;
        state_d = DIV;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign N         = n_q;
  assign err_det   = det_q;
  assign err_corr  = corr_q;
  assign err_pos   = pos_q;
  assign err_neg   = neg_q;
`ifdef AN_SEC_UNCORR_EN
  assign uncorr    = uncorr_q;
`endif

endmodule

// File: tb/tb_an_sec_decoder.sv
// ---------------------------------------------------------------------------
// tb_an_sec_decoder
//
// Directed bench for an_sec_decoder with A=67. dut uses the default
// L_MAX=33. dut2 uses L_MAX=32 so that a residue of 33 has no matching
// position. The two instances share W and out_ready but have separate
// in_valid lines, so dut2 only runs when it is addressed.
// ---------------------------------------------------------------------------
module tb_an_sec_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_valid2;
  logic [31:0] W;
  logic        out_ready;

  logic        in_ready, out_valid, err_det, err_corr, err_neg;
  logic [24:0] N;
  logic [5:0]  err_pos;
  logic        in_ready2, out_valid2, err_det2, err_corr2, err_neg2;
  logic [24:0] N2;
  logic [5:0]  err_pos2;
`ifdef AN_SEC_UNCORR_EN
  logic        uncorr, uncorr2;
`endif

  int checks;
  int errors;

  an_sec_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .W(W),
    .out_valid(out_valid), .out_ready(out_ready), .N(N), .err_det(err_det),
    .err_corr(err_corr), .err_pos(err_pos), .err_neg(err_neg)
`ifdef AN_SEC_UNCORR_EN
    , .uncorr(uncorr)
`endif
  );

  an_sec_decoder #(.L_MAX(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .W(W),
    .out_valid(out_valid2), .out_ready(out_ready), .N(N2), .err_det(err_det2),
    .err_corr(err_corr2), .err_pos(err_pos2), .err_neg(err_neg2)
`ifdef AN_SEC_UNCORR_EN
    , .uncorr(uncorr2)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for the selected instance to go idle and hands it one word. It then
  // counts cycles until out_valid. The acceptance cycle is cycle 0, and lat
  // returns 0 if the result never appears. With noise set, in_valid is
  // toggled with a junk W early in the decode, which the busy DUT must ignore.
  task automatic applyStimulus(input logic [31:0] w, input bit use2, input bit noise,
                               output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(use2 ? in_ready2 : in_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    W = w;
    if (use2) in_valid2 = 1'b1;
    else in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      if (noise && i < 10) begin
        in_valid = 1'b1;
        W = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b0;
      end
      if ((use2 ? out_valid2 : out_valid) === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (lat == 0) begin
      errors++;
      $display("[TB] FAIL timeout: out_valid not seen for W=%0d", w);
    end
  endtask

  // Reset state, checked while rst_n is still low.
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 6;
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (N !== 25'd0)        begin errors++; $display("[TB] FAIL reset_N got=%0d exp=0", N); end
    if (err_det !== 1'b0 || err_corr !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got=%b%b exp=00", err_det, err_corr); end
    if (err_pos !== 6'd0)   begin errors++; $display("[TB] FAIL reset_err_pos got=%0d exp=0", err_pos); end
    if (err_neg !== 1'b0)   begin errors++; $display("[TB] FAIL reset_err_neg got=%b exp=0", err_neg); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Clean codewords, including zero, a quotient truncated to 25 bits, and a
  // noisy in_valid while the decoder is busy.
  task automatic test_no_error();
    int lat;
    logic [31:0] wv [4];
    logic [24:0] nv [4];
    wv = '{32'd67000, 32'd0, 32'd4294867232, 32'd67000};
    nv = '{25'd1000, 25'd0, 25'd30548064, 25'd1000};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(wv[i], 1'b0, (i == 3), lat);
      checks += 3;
      if (lat !== 34) begin errors++; $display("[TB] FAIL noerr_latency[%0d] got=%0d exp=34", i, lat); end
      if (N !== nv[i]) begin errors++; $display("[TB] FAIL noerr_N[%0d] got=%0d exp=%0d", i, N, nv[i]); end
      if (err_det !== 1'b0 || err_corr !== 1'b0) begin
        errors++; $display("[TB] FAIL noerr_flags[%0d] got det=%b corr=%b exp=00", i, err_det, err_corr);
      end
    end
  endtask

  // Single-bit errors in both directions at several positions.
  task automatic test_single_error();
    int lat;
    logic [31:0] wv [5];
    logic [5:0]  pv [5];
    logic        gv [5];
    wv = '{32'd67016, 32'd66992, 32'd67001, 32'd66999, 32'd1115576};
    pv = '{6'd4, 6'd3, 6'd0, 6'd0, 6'd20};
    gv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(wv[i], 1'b0, 1'b0, lat);
      checks += 4;
      if (N !== 25'd1000) begin errors++; $display("[TB] FAIL corr_N[%0d] got=%0d exp=1000", i, N); end
      if (err_det !== 1'b1 || err_corr !== 1'b1) begin
        errors++; $display("[TB] FAIL corr_flags[%0d] got det=%b corr=%b exp=11", i, err_det, err_corr);
      end
      if (err_pos !== pv[i]) begin errors++; $display("[TB] FAIL corr_pos[%0d] got=%0d exp=%0d", i, err_pos, pv[i]); end
      if (err_neg !== gv[i]) begin errors++; $display("[TB] FAIL corr_neg[%0d] got=%b exp=%b", i, err_neg, gv[i]); end
`ifdef AN_SEC_UNCORR_EN
      checks++;
      if (uncorr !== 1'b0) begin errors++; $display("[TB] FAIL corr_uncorr[%0d] got=%b exp=0", i, uncorr); end
`endif
    end
  endtask

  // Residue 33 with L_MAX=32: no position matches, so the floor quotient is kept.
  task automatic test_uncorrectable();
    int lat;
    applyStimulus(32'd67033, 1'b1, 1'b0, lat);
    checks += 4;
    if (lat !== 66)       begin errors++; $display("[TB] FAIL uncorr_latency got=%0d exp=66", lat); end
    if (N2 !== 25'd1000)  begin errors++; $display("[TB] FAIL uncorr_N got=%0d exp=1000", N2); end
    if (err_det2 !== 1'b1) begin errors++; $display("[TB] FAIL uncorr_det got=%b exp=1", err_det2); end
    if (err_corr2 !== 1'b0) begin errors++; $display("[TB] FAIL uncorr_corr got=%b exp=0", err_corr2); end
`ifdef AN_SEC_UNCORR_EN
    checks++;
    if (uncorr2 !== 1'b1) begin errors++; $display("[TB] FAIL uncorr_flag got=%b exp=1", uncorr2); end
`endif
  endtask

  // Hold the result for 5 cycles. Then check that a word offered during the
  // handoff cycle is not taken.
  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    applyStimulus(32'd67016, 1'b0, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks += 3;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_handshake[%0d] got valid=%b ready=%b exp=10", c, out_valid, in_ready);
      end
      if (N !== 25'd1000) begin errors++; $display("[TB] FAIL hold_N[%0d] got=%0d exp=1000", c, N); end
      if (err_pos !== 6'd4 || err_corr !== 1'b1) begin
        errors++; $display("[TB] FAIL hold_err[%0d] got pos=%0d corr=%b exp=4,1", c, err_pos, err_corr);
      end
    end
    out_ready = 1'b1;
    W = 32'd67000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL handoff_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL handoff_not_accepted got=%b exp=1", in_ready); end
  endtask

  // Reset pulsed in the middle of a search. No stale result may appear, and
  // the next word must decode normally.
  task automatic test_reset_mid_search();
    int lat;
    bit seen;
    @(negedge clk);
    W = 32'd67016;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks += 3;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_handshake got ready=%b valid=%b exp=10", in_ready, out_valid);
    end
    if (N !== 25'd0) begin errors++; $display("[TB] FAIL midrst_N got=%0d exp=0", N); end
    if (err_det !== 1'b0 || err_corr !== 1'b0 || err_pos !== 6'd0) begin
      errors++; $display("[TB] FAIL midrst_flags got det=%b corr=%b pos=%0d exp=0", err_det, err_corr, err_pos);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL midrst_stale_result got=1 exp=0"); end
    applyStimulus(32'd67000, 1'b0, 1'b0, lat);
    checks += 3;
    if (lat !== 34) begin errors++; $display("[TB] FAIL midrst_latency got=%0d exp=34", lat); end
    if (N !== 25'd1000) begin errors++; $display("[TB] FAIL midrst_N_after got=%0d exp=1000", N); end
    if (err_det !== 1'b0) begin errors++; $display("[TB] FAIL midrst_det_after got=%b exp=0", err_det); end
  endtask

  // Test sequence.
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    W         = '0;
    out_ready = 1'b1;
    test_reset();
    test_no_error();
    test_single_error();
    test_uncorrectable();
    test_backpressure();
    test_reset_mid_search();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
